// File: rtl/dac_wave_sequencer_if.sv
// dac_wave_sequencer_if: register-bank, sample-memory and DAC-side signals of the playback sequencer
interface dac_wave_sequencer_if #(
  parameter int DAC_WIDTH  = 10,
  parameter int ADDR_WIDTH = 14,
  parameter int DIV_WIDTH  = 16
);
  logic                  Cfg_Start;
  logic                  Cfg_Stop;
  logic                  Cfg_Loop;
  logic [ADDR_WIDTH-1:0] Cfg_BaseAddr;
  logic [ADDR_WIDTH-1:0] Cfg_Length;
  logic [DIV_WIDTH-1:0]  Cfg_RateDiv;
  logic                  Mem_Rd;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [DAC_WIDTH-1:0]  Mem_RdData;
  logic [DAC_WIDTH-1:0]  DAC_Data;
  logic                  DAC_Valid;
  logic                  Busy;
  logic                  Done_Irq;
  logic                  Dac_Pwrdn;
  modport master (
    output Cfg_Start, Cfg_Stop, Cfg_Loop, Cfg_BaseAddr, Cfg_Length, Cfg_RateDiv, Mem_RdData,
    input  Mem_Rd, Mem_Addr, DAC_Data, DAC_Valid, Busy, Done_Irq, Dac_Pwrdn
  );
  modport slave (
    input  Cfg_Start, Cfg_Stop, Cfg_Loop, Cfg_BaseAddr, Cfg_Length, Cfg_RateDiv, Mem_RdData,
    output Mem_Rd, Mem_Addr, DAC_Data, DAC_Valid, Busy, Done_Irq, Dac_Pwrdn
  );
endinterface

// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: paced one-shot/loop playback from sample memory to the DAC register.
// Optional DAC_SEQ_AUTO_PWRDN_EN adds a WAKE phase and drives Dac_Pwrdn while idle.
module dac_wave_sequencer #(
  parameter int DAC_WIDTH   = 10,
  parameter int ADDR_WIDTH  = 14,
  parameter int DIV_WIDTH   = 16,
  parameter int WAKE_CYCLES = 64
) (
  input logic SPLB_Clk,
  input logic SPLB_Rst,
  dac_wave_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
`ifdef DAC_SEQ_AUTO_PWRDN_EN
    WAKE,
`endif
    FETCH,
    WAITD,
    RUN
  } state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] base, len, idx, idx_n, mem_addr;
  logic [DIV_WIDTH-1:0] per, cnt;
  logic [DAC_WIDTH-1:0] hold, dac_data;
  logic loop_m, last, rd_d, mem_rd, dac_valid, done_irq;
  logic start_ok, stop_now, emit, cont, at_end;
`ifdef DAC_SEQ_AUTO_PWRDN_EN
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  logic [WW-1:0] wake_cnt;
`endif
  // emit marks the edge that loads the next sample, so DAC_Valid shows in the following cycle
  always_comb begin
    start_ok = bus.Cfg_Start && !bus.Cfg_Stop && (bus.Cfg_Length != '0);
    stop_now = bus.Cfg_Stop && (state != IDLE);
    emit = (state == WAITD) || (state == RUN && cnt == '0 && !last);
    at_end = idx == len - 1'b1;
    idx_n = at_end ? '0 : idx + 1'b1;
    cont = !(at_end && !loop_m);
    state_n = state;
    case (state)
`ifdef DAC_SEQ_AUTO_PWRDN_EN
      IDLE:  state_n = start_ok ? WAKE : IDLE;
      WAKE:  state_n = wake_cnt == '0 ? FETCH : WAKE;
`else
      IDLE:  state_n = start_ok ? FETCH : IDLE;
`endif
      FETCH: state_n = WAITD;
      WAITD: state_n = RUN;
      RUN:   state_n = last ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
    if (stop_now) state_n = IDLE;
  end
  always_ff @(posedge SPLB_Clk) state <= SPLB_Rst ? IDLE : state_n;
  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst) begin
      base <= '0;
      len <= '0;
      per <= '0;
      loop_m <= 1'b0;
      idx <= '0;
      cnt <= '0;
      hold <= '0;
      last <= 1'b0;
      rd_d <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      dac_data <= '0;
      dac_valid <= 1'b0;
      done_irq <= 1'b0;
`ifdef DAC_SEQ_AUTO_PWRDN_EN
      wake_cnt <= '0;
`endif
    end else begin
      mem_rd <= 1'b0;
      dac_valid <= 1'b0;
      done_irq <= 1'b0;
      rd_d <= mem_rd && !stop_now;
      if (rd_d) hold <= bus.Mem_RdData;
      if (state == IDLE && start_ok) begin
        base <= bus.Cfg_BaseAddr;
        len <= bus.Cfg_Length;
        per <= bus.Cfg_RateDiv == '0 ? DIV_WIDTH'(1) : bus.Cfg_RateDiv;
        loop_m <= bus.Cfg_Loop;
        idx <= '0;
        last <= 1'b0;
`ifdef DAC_SEQ_AUTO_PWRDN_EN
        wake_cnt <= WW'(WAKE_CYCLES - 1);
`else
        mem_rd <= 1'b1;
        mem_addr <= bus.Cfg_BaseAddr;
`endif
      end
`ifdef DAC_SEQ_AUTO_PWRDN_EN
      if (state == WAKE) begin
        wake_cnt <= wake_cnt - 1'b1;
        if (wake_cnt == '0 && !stop_now) begin
          mem_rd <= 1'b1;
          mem_addr <= base;
        end
      end
`endif
      // with the shortest period the read data arrives on the emit cycle itself, so bypass hold
      if (emit && !stop_now) begin
        dac_data <= rd_d ? bus.Mem_RdData : hold;
        dac_valid <= 1'b1;
        cnt <= per;
        if (cont) begin
          idx <= idx_n;
          mem_rd <= 1'b1;
          mem_addr <= base + idx_n;
        end else begin
          last <= 1'b1;
        end
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == RUN && last && !stop_now) done_irq <= 1'b1;
    end
  end
  assign bus.Mem_Rd = mem_rd;
  assign bus.Mem_Addr = mem_addr;
  assign bus.DAC_Data = dac_data;
  assign bus.DAC_Valid = dac_valid;
  assign bus.Busy = state != IDLE;
  assign bus.Done_Irq = done_irq;
`ifdef DAC_SEQ_AUTO_PWRDN_EN
  assign bus.Dac_Pwrdn = state == IDLE;
`else
  assign bus.Dac_Pwrdn = 1'b0;
`endif
endmodule

// File: tb/tb_dac_wave_sequencer.sv
// tb_dac_wave_sequencer: scoreboard bench; a timeline model predicts DAC samples, reads, Busy and Done
module tb_dac_wave_sequencer;
  localparam int AW = 14;
  localparam int DW = 10;
  localparam int VW = 16;
`ifdef DAC_SEQ_AUTO_PWRDN_EN
  localparam int W = 64;
  localparam bit PD = 1'b1;
`else
  localparam int W = 0;
  localparam bit PD = 1'b0;
`endif
  typedef struct {int cyc; logic [DW-1:0] data;} ev_t;
  typedef struct {int cyc; logic [AW-1:0] addr;} rd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  ev_t dac_q[$];
  rd_t rd_q[$];
  int done_q[$];
  int cyc = 0, total = 0, bad = 0, busy_lo = 0, busy_hi = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;
  dac_wave_sequencer_if bus();
  dac_wave_sequencer dut(.SPLB_Clk(clk), .SPLB_Rst(rst), .bus(bus));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.Mem_Rd) bus.Mem_RdData <= mem[bus.Mem_Addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask
  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] l, input int j);
    return AW'(int'(b) + j % int'(l));
  endfunction
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    rd_t r;
    bit bz;
    if (armed) begin
      bz = cyc >= busy_lo && cyc < busy_hi;
      chk("busy", bus.Busy, bz);
      chk("pwrdn", bus.Dac_Pwrdn, PD && !bz);
      if (bus.DAC_Valid) begin
        chk("dac_expected", dac_q.size() != 0, 1);
        if (dac_q.size() != 0) begin
          e = dac_q.pop_front();
          chk("dac_cyc", cyc, e.cyc);
          chk("dac_data", bus.DAC_Data, e.data);
        end
      end
      if (bus.Mem_Rd) begin
        chk("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          if (r.cyc >= 0) chk("rd_cyc", cyc, r.cyc);
          chk("rd_addr", bus.Mem_Addr, r.addr);
        end
      end
      if (bus.Done_Irq) begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) chk("done_cyc", cyc, done_q.pop_front());
      end
    end
  end
  // stop_after>0 ends playback by Stop (or reset if use_rst) right after that many samples
  task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic [VW-1:0] div,
                     input bit lp, input int stop_after, input bit same, input bit use_rst, input bit poke);
    int k, p, n_out, s, t0;
    ev_t e;
    rd_t r;
    logic [DW-1:0] last_v;
    @(posedge clk);
    #1;
    k = cyc;
    bus.Cfg_BaseAddr = base;
    bus.Cfg_Length = len;
    bus.Cfg_RateDiv = div;
    bus.Cfg_Loop = lp;
    bus.Cfg_Start = 1'b1;
    bus.Cfg_Stop = same;
    if (same || len == 0) begin
      @(posedge clk);
      #1;
      bus.Cfg_Start = 1'b0;
      bus.Cfg_Stop = 1'b0;
      wait_until(k + 8);
      chk("idle_busy", bus.Busy, 0);
      return;
    end
    p = (div == 0 ? 1 : int'(div)) + 1;
    t0 = k + 3 + W;
    n_out = stop_after > 0 ? stop_after : int'(len);
    for (int n = 0; n < n_out; n++) begin
      e.cyc = t0 + n * p;
      e.data = mem[addr_of(base, len, n)];
      dac_q.push_back(e);
    end
    for (int j = 0; j <= (stop_after > 0 ? n_out : n_out - 1); j++) begin
      r.cyc = j == 0 ? k + 1 + W : -1;
      r.addr = addr_of(base, len, j);
      rd_q.push_back(r);
    end
    last_v = mem[addr_of(base, len, n_out - 1)];
    s = t0 + (n_out - 1) * p + 1;
    busy_lo = k + 1;
    busy_hi = stop_after > 0 ? s + 1 : s;
    if (stop_after == 0) done_q.push_back(s);
    @(posedge clk);
    #1;
    bus.Cfg_Start = 1'b0;
    bus.Cfg_BaseAddr = AW'($urandom);
    bus.Cfg_Length = AW'($urandom_range(1, 9));
    bus.Cfg_RateDiv = VW'($urandom_range(0, 7));
    bus.Cfg_Loop = 1'($urandom);
    if (poke) begin
      bus.Cfg_Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Cfg_Start = 1'b0;
    end
    if (stop_after > 0) begin
      wait_until(s);
      if (use_rst) rst = 1'b1;
      else bus.Cfg_Stop = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.Cfg_Stop = 1'b0;
      rd_q.delete();
      if (use_rst) begin
        chk("rst_mem_rd", bus.Mem_Rd, 0);
        chk("rst_mem_addr", bus.Mem_Addr, 0);
        chk("rst_dac_valid", bus.DAC_Valid, 0);
        chk("rst_done", bus.Done_Irq, 0);
      end
    end else begin
      wait_until(busy_hi + 4);
      chk("rd_left", rd_q.size(), 0);
    end
    wait_until(busy_hi + 4 + p);
    chk("dac_left", dac_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    chk("dac_hold", bus.DAC_Data, use_rst ? '0 : 32'(last_v));
  endtask
  initial begin
    #(4000000);
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int ln, st;
    bit lp;
    bus.Cfg_Start = 1'b0;
    bus.Cfg_Stop = 1'b0;
    bus.Cfg_Loop = 1'b0;
    bus.Cfg_BaseAddr = '0;
    bus.Cfg_Length = '0;
    bus.Cfg_RateDiv = '0;
    foreach (mem[i]) mem[i] = DW'($urandom);
    mem[16'h10] = 10'h001;
    mem[16'h11] = 10'h0FF;
    mem[16'h12] = 10'h200;
    mem[16'h13] = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_rd", bus.Mem_Rd, 0);
    chk("reset_mem_addr", bus.Mem_Addr, 0);
    chk("reset_dac_data", bus.DAC_Data, 0);
    chk("reset_dac_valid", bus.DAC_Valid, 0);
    chk("reset_busy", bus.Busy, 0);
    chk("reset_done", bus.Done_Irq, 0);
    chk("reset_pwrdn", bus.Dac_Pwrdn, PD);
    rst = 1'b0;
    armed = 1'b1;
    run(14'h0010, 14'd4, 16'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(14'h0100, 14'd3, 16'd1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    run(14'h3FFE, 14'd4, 16'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(14'h0200, 14'd5, 16'd2, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    run(14'h0222, 14'd3, 16'd2, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    run(14'h0300, 14'd3, 16'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(14'h0300, 14'd3, 16'd0, 1'b1, 7, 1'b0, 1'b0, 1'b0);
    run(14'h0400, 14'd0, 16'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run(14'h0050, 14'd5, 16'd4, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      lp = 1'($urandom);
      ln = $urandom_range(1, 6);
      st = lp ? $urandom_range(1, 8) : ((ln > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, ln - 1) : 0);
      run(AW'($urandom), AW'(ln), VW'($urandom_range(0, 5)), lp, st, 1'b0, 1'b0, 1'($urandom));
    end
    run(14'h0123, 14'd5, 16'd2, 1'b1, 4, 1'b0, 1'b1, 1'b0);
    run(14'h0010, 14'd4, 16'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
